fft4_stream: RTL and testbench

//  Streaming 4-point complex FFT/IFFT with valid/ready handshakes on both sides. Parametrised successor of the fixed 16-bit parallel FFT4.

---
 rtl/fft4_stream_pkg.sv | 54 +++++
 rtl/fft4_stream_if.sv | 28 ++
 rtl/fft4_stream_bfly.sv | 83 ++++++++
 rtl/fft4_stream.sv | 144 ++++++++++++++
 tb/tb_fft4_stream.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft4_stream_pkg.sv
// Shared types, constants and complex helpers for the streaming 4-point FFT.
// FFT4_ROUND_EN selects the divide-by-4 rounded output width (OW=DW) instead of full growth (OW=DW+2).
package fft_pkg;

    localparam int FFT_DW = 16;
    // Internal working width; wide enough for full 4-point growth of any practical DW.
    localparam int CW = 40;

    localparam logic [1:0] BIN_X0 = 2'd0;
    localparam logic [1:0] BIN_X1 = 2'd1;
    localparam logic [1:0] BIN_X2 = 2'd2;
    localparam logic [1:0] BIN_X3 = 2'd3;

    typedef struct packed {
        logic signed [CW-1:0] re;
        logic signed [CW-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {
        OUT_IDLE  = 1'b0,
        OUT_DRAIN = 1'b1
    } out_state_e;

    function automatic int fft_ow(input int dw);
`ifdef FFT4_ROUND_EN
        return dw;
`else
        return dw + 2;
`endif
    endfunction

    function automatic cplx_t cplx_add(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re + y.re;
        r.im = x.im + y.im;
        return r;
    endfunction

    function automatic cplx_t cplx_sub(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re - y.re;
        r.im = x.im - y.im;
        return r;
    endfunction

    // j*(re + j*im) = -im + j*re
    function automatic cplx_t mul_j(input cplx_t x);
        cplx_t r;
        r.re = -x.im;
        r.im = x.re;
        return r;
    endfunction

endpackage

// File: rtl/fft4_stream_if.sv
// Sample-in / bin-out handshake bundle of fft4_stream; slave is the FFT side, master the environment.
interface fft4_stream_if #(
    parameter int DW = fft_pkg::FFT_DW,
    parameter int OW = fft_pkg::fft_ow(DW)
) ();

    logic            s_valid;
    logic            s_ready;
    logic [2*DW-1:0] s_data;
    logic            s_last;
    logic            s_inv;
    logic            m_valid;
    logic            m_ready;
    logic [2*OW-1:0] m_data;
    logic [1:0]      m_index;
    logic            m_last;

    modport slave (
        input  s_valid, s_data, s_last, s_inv, m_ready,
        output s_ready, m_valid, m_data, m_index, m_last
    );

    modport master (
        output s_valid, s_data, s_last, s_inv, m_ready,
        input  s_ready, m_valid, m_data, m_index, m_last
    );

endinterface

// File: rtl/fft4_stream_bfly.sv
// Registered 4-point radix-4 butterfly; loads all four bins in one edge when load_i is high.
// With FFT4_ROUND_EN each bin is rounded half-up by 1/4 and saturated to OW bits.
module fft4_bfly
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int OW = fft_ow(DW)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_i,
    input  logic            inv_i,
    input  logic [2*DW-1:0] x_i   [4],
    output logic [2*OW-1:0] bin_o [4]
);

`ifdef FFT4_ROUND_EN
    localparam logic signed [CW-1:0] RND_C   = CW'(32'sd2);
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

    cplx_t           a_s, b_s, c_s, d_s, sum_ac_s, dif_ac_s, sum_bd_s, jdif_bd_s;
    cplx_t           y_s   [4];
    logic [2*OW-1:0] bin_q [4];

    function automatic cplx_t widen(input logic [2*DW-1:0] smp);
        cplx_t r;
        r.re = CW'($signed(smp[DW-1:0]));
        r.im = CW'($signed(smp[2*DW-1:DW]));
        return r;
    endfunction

    function automatic logic [OW-1:0] narrow(input logic signed [CW-1:0] v);
`ifdef FFT4_ROUND_EN
        logic signed [CW-1:0] t;
        t = (v + RND_C) >>> 2;
        if (t > SAT_MAX) begin
            t = SAT_MAX;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
        end else begin
            t = t;
        end
        return t[OW-1:0];
`else
        return v[OW-1:0];
`endif
    endfunction

    // Butterfly arithmetic; inverse flips the sign of the j-rotated odd term.
    always_comb begin
        a_s       = widen(x_i[0]);
        b_s       = widen(x_i[1]);
        c_s       = widen(x_i[2]);
        d_s       = widen(x_i[3]);
        sum_ac_s  = cplx_add(a_s, c_s);
        dif_ac_s  = cplx_sub(a_s, c_s);
        sum_bd_s  = cplx_add(b_s, d_s);
        jdif_bd_s = mul_j(cplx_sub(b_s, d_s));
        y_s[BIN_X0] = cplx_add(sum_ac_s, sum_bd_s);
        y_s[BIN_X2] = cplx_sub(sum_ac_s, sum_bd_s);
        if (inv_i) begin
            y_s[BIN_X1] = cplx_add(dif_ac_s, jdif_bd_s);
            y_s[BIN_X3] = cplx_sub(dif_ac_s, jdif_bd_s);
        end else begin
            y_s[BIN_X1] = cplx_sub(dif_ac_s, jdif_bd_s);
            y_s[BIN_X3] = cplx_add(dif_ac_s, jdif_bd_s);
        end
    end

    // Output bin registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) bin_q[i] <= '0;
        end else if (load_i) begin
            for (int i = 0; i < 4; i++) bin_q[i] <= {narrow(y_s[i].im), narrow(y_s[i].re)};
        end
    end

    assign bin_o = bin_q;

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point FFT/IFFT: collects 4-sample frames, transforms in one step, drains bins 0..3.
// Output width follows FFT4_ROUND_EN (see fft_pkg::fft_ow).
module fft4_stream
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW
) (
    input  logic           clk,
    input  logic           rstn,
    fft4_stream_if.slave   bus,
    output logic           err
);

    localparam int OW = fft_ow(DW);

    logic [1:0]      in_idx_q, in_idx_d;
    logic            in_full_q, in_full_d;
    logic            inv_q, inv_d;
    logic            err_q, err_d;
    logic [2*DW-1:0] x_q [4];
    out_state_e      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            accept_s, bad_s, last_acc_s, xfer_s;
    logic [2*OW-1:0] bin_s [4];

    assign accept_s   = bus.s_valid && !in_full_q;
    assign bad_s      = accept_s && (bus.s_last != (in_idx_q == 2'd3));
    assign last_acc_s = (state_q == OUT_DRAIN) && (idx_q == BIN_X3) && bus.m_ready;
    // A full input frame moves into the butterfly when the output side is free or freeing this cycle.
    assign xfer_s     = in_full_q && ((state_q == OUT_IDLE) || last_acc_s);

    // Input framing next-state.
    always_comb begin
        in_idx_d  = in_idx_q;
        in_full_d = in_full_q;
        inv_d     = inv_q;
        err_d     = 1'b0;
        if (bad_s) begin
            err_d    = 1'b1;
            in_idx_d = 2'd0;
        end else if (accept_s) begin
            in_idx_d  = in_idx_q + 2'd1;
            in_full_d = (in_idx_q == 2'd3);
            if (in_idx_q == 2'd0) begin
                inv_d = bus.s_inv;
            end else begin
                inv_d = inv_q;
            end
        end else if (xfer_s) begin
            in_full_d = 1'b0;
        end else begin
            in_full_d = in_full_q;
        end
    end

    // Input state registers and sample buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_idx_q  <= 2'd0;
            in_full_q <= 1'b0;
            inv_q     <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 4; i++) x_q[i] <= '0;
        end else begin
            in_idx_q  <= in_idx_d;
            in_full_q <= in_full_d;
            inv_q     <= inv_d;
            err_q     <= err_d;
            if (accept_s) x_q[in_idx_q] <= bus.s_data;
        end
    end

    fft4_bfly #(.DW(DW), .OW(OW)) u_bfly (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (xfer_s),
        .inv_i  (inv_q),
        .x_i    (x_q),
        .bin_o  (bin_s)
    );

    // Output FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= OUT_IDLE;
            idx_q   <= BIN_X0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Output FSM next-state; a transfer on the final-bin handshake reloads with no bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            OUT_IDLE: begin
                if (xfer_s) begin
                    state_d = OUT_DRAIN;
                    idx_d   = BIN_X0;
                end else begin
                    state_d = OUT_IDLE;
                end
            end
            OUT_DRAIN: begin
                if (bus.m_ready && (idx_q == BIN_X3)) begin
                    state_d = xfer_s ? OUT_DRAIN : OUT_IDLE;
                    idx_d   = BIN_X0;
                end else if (bus.m_ready) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = OUT_IDLE;
                idx_d   = BIN_X0;
            end
        endcase
    end

    // Output FSM outputs.
    always_comb begin
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        case (state_q)
            OUT_DRAIN: begin
                bus.m_valid = 1'b1;
                bus.m_last  = (idx_q == BIN_X3);
            end
            default: begin
                bus.m_valid = 1'b0;
                bus.m_last  = 1'b0;
            end
        endcase
    end

    assign bus.m_index = idx_q;
    assign bus.m_data  = bin_s[idx_q];
    assign bus.s_ready = !in_full_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fft4_stream.sv
// Self-checking bench for fft4_stream: table vectors, framing/backpressure/reset sequences, random frames.
`timescale 1ns/1ps
module tb_fft4_stream;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int OW = fft_ow(DW);

    typedef int     arr4_t  [4];
    typedef longint larr4_t [4];

    typedef struct {
        logic [2*OW-1:0] data;
        logic [1:0]      index;
        logic            last;
    } exp_t;

    typedef struct {
        string  name;
        arr4_t  in_re;
        arr4_t  in_im;
        bit     inv;
        larr4_t ex_re;
        larr4_t ex_im;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    logic err;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 0;
    exp_t sb_q[$];
    vec_t vec [6];

    always #5 clk = ~clk;

    fft4_stream_if #(.DW(DW)) bus ();

    fft4_stream #(.DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave),
        .err  (err)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic longint scale(input longint v);
`ifdef FFT4_ROUND_EN
        longint t;
        t = (v + 64'sd2) >>> 2;
        if (t > 64'sd32767) t = 64'sd32767;
        if (t < -64'sd32768) t = -64'sd32768;
        return t;
`else
        return v;
`endif
    endfunction

    // Direct DFT: X_k = sum x_n * w^(nk), w = -j forward, +j inverse.
    task automatic dft(input arr4_t re, input arr4_t im, input bit inv, output larr4_t xr, output larr4_t xi);
        for (int k = 0; k < 4; k++) begin
            xr[k] = 0;
            xi[k] = 0;
            for (int n = 0; n < 4; n++) begin
                int r;
                r = inv ? ((n * k) % 4) : ((3 * n * k) % 4);
                case (r)
                    0: begin xr[k] += re[n]; xi[k] += im[n]; end
                    1: begin xr[k] -= im[n]; xi[k] += re[n]; end
                    2: begin xr[k] -= re[n]; xi[k] -= im[n]; end
                    default: begin xr[k] += im[n]; xi[k] -= re[n]; end
                endcase
            end
        end
    endtask

    task automatic push_bins(input larr4_t xr, input larr4_t xi);
        for (int k = 0; k < 4; k++) begin
            exp_t   e;
            longint sr, si;
            sr      = scale(xr[k]);
            si      = scale(xi[k]);
            e.data  = {si[OW-1:0], sr[OW-1:0]};
            e.index = k[1:0];
            e.last  = (k == 3);
            sb_q.push_back(e);
        end
    endtask

    // Drive one beat and hold it until accepted; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input int re, input int im, input bit last, input bit inv);
        bit acc;
        logic [DW-1:0] r16, i16;
        r16 = re[DW-1:0];
        i16 = im[DW-1:0];
        bus.s_valid = 1'b1;
        bus.s_data  = {i16, r16};
        bus.s_last  = last;
        bus.s_inv   = inv;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept_timeout: got s_ready=0 for 200 cycles, required 1");
        end
    endtask

    task automatic send_frame(input arr4_t re, input arr4_t im, input bit inv, input larr4_t xr, input larr4_t xi);
        for (int n = 0; n < 4; n++) begin
            send_beat(re[n], im[n], n == 3, inv);
            check("err_quiet", err, 1'b0);
        end
        push_bins(xr, xi);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sb_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d bins outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every accepted bin against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bus.m_valid && bus.m_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bin: got bin index %0d, required no output", bus.m_index);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("bin_data", bus.m_data, e.data);
                    check("bin_index", bus.m_index, e.index);
                    check("bin_last", bus.m_last, e.last);
                end
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = stalled, otherwise random.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = 1'b0;
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arr4_t  bp_re [3];
        arr4_t  bp_im [3];
        arr4_t  rr, ri;
        larr4_t xr, xi;
        int     beat;
        bit     acc;

        vec[0] = '{"impulse",     '{100, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, '{100, 100, 100, 100}, '{0, 0, 0, 0}};
        vec[1] = '{"dc",          '{1000, 1000, 1000, 1000}, '{0, 0, 0, 0}, 1'b0, '{4000, 0, 0, 0}, '{0, 0, 0, 0}};
        vec[2] = '{"tone_fwd",    '{1000, 0, -1000, 0}, '{0, 1000, 0, -1000}, 1'b0, '{0, 4000, 0, 0}, '{0, 0, 0, 0}};
        vec[3] = '{"tone_inv",    '{1000, 0, -1000, 0}, '{0, 1000, 0, -1000}, 1'b1, '{0, 0, 0, 4000}, '{0, 0, 0, 0}};
        vec[4] = '{"extremes",    '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 1'b0,
                   '{-131072, 0, 0, 0}, '{-131072, 0, 0, 0}};
        vec[5] = '{"impulse_inv", '{100, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, '{100, 100, 100, 100}, '{0, 0, 0, 0}};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.s_inv   = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", bus.s_ready, 1'b1);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_data", bus.m_data, '0);
        check("rst_m_index", bus.m_index, 2'd0);
        check("rst_m_last", bus.m_last, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, each with a first-bin latency check.
        for (int v = 0; v < 6; v++) begin
            send_frame(vec[v].in_re, vec[v].in_im, vec[v].inv, vec[v].ex_re, vec[v].ex_im);
            check("lat_before", bus.m_valid, 1'b0);
            @(posedge clk);
            #1;
            check("lat_valid", bus.m_valid, 1'b1);
            check("lat_index", bus.m_index, 2'd0);
            wait_drain();
        end

        // Framing: s_last on the 2nd sample, then s_last missing on the 4th.
        send_beat(5, 5, 1'b0, 1'b0);
        send_beat(6, 6, 1'b1, 1'b0);
        check("err_early_last", err, 1'b1);
        @(posedge clk);
        #1;
        check("err_one_cycle", err, 1'b0);
        for (int n = 0; n < 4; n++) send_beat(7, 7, 1'b0, 1'b0);
        check("err_missing_last", err, 1'b1);
        @(posedge clk);
        #1;
        send_frame(vec[2].in_re, vec[2].in_im, 1'b0, vec[2].ex_re, vec[2].ex_im);
        wait_drain();

        // Backpressure: 12 cycles with m_ready low while offering 12 samples.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 4; n++) begin
                bp_re[f][n] = int'($urandom_range(0, 65535)) - 32768;
                bp_im[f][n] = int'($urandom_range(0, 65535)) - 32768;
            end
        end
        beat = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic [DW-1:0] r16, i16;
            r16 = bp_re[beat / 4][beat % 4][DW-1:0];
            i16 = bp_im[beat / 4][beat % 4][DW-1:0];
            bus.s_valid = 1'b1;
            bus.s_data  = {i16, r16};
            bus.s_last  = (beat % 4 == 3);
            bus.s_inv   = 1'b0;
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (beat % 4 == 3) begin
                    dft(bp_re[beat / 4], bp_im[beat / 4], 1'b0, xr, xi);
                    push_bins(xr, xi);
                end
                beat++;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("bp_accepted", 64'(beat), 64'd8);
        check("bp_s_ready", bus.s_ready, 1'b0);
        check("bp_m_valid", bus.m_valid, 1'b1);
        check("bp_m_index_held", bus.m_index, 2'd0);
        rdy_mode = 0;
        dft(bp_re[2], bp_im[2], 1'b0, xr, xi);
        send_frame(bp_re[2], bp_im[2], 1'b0, xr, xi);
        wait_drain();

        // Reset in the middle of a drain.
        send_frame(vec[0].in_re, vec[0].in_im, 1'b0, vec[0].ex_re, vec[0].ex_im);
        for (int t = 0; t < 20 && sb_q.size() > 3; t++) begin
            @(posedge clk);
            #1;
        end
        check("mid_drain_reached", bus.m_index, 2'd1);
        rstn = 1'b0;
        #1;
        check("rst_drain_m_valid", bus.m_valid, 1'b0);
        check("rst_drain_s_ready", bus.s_ready, 1'b1);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_frame(vec[1].in_re, vec[1].in_im, 1'b0, vec[1].ex_re, vec[1].ex_im);
        wait_drain();

        // Random frames against the DFT model with random downstream stalls.
        rdy_mode = 2;
        for (int f = 0; f < 20; f++) begin
            bit inv;
            for (int n = 0; n < 4; n++) begin
                rr[n] = int'($urandom_range(0, 65535)) - 32768;
                ri[n] = int'($urandom_range(0, 65535)) - 32768;
            end
            inv = 1'($urandom_range(0, 1));
            dft(rr, ri, inv, xr, xi);
            send_frame(rr, ri, inv, xr, xi);
        end
        wait_drain();
        rdy_mode = 0;
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
